dram_port_arbiter: RTL and testbench
====================================

Name: dram_port_arbiter

Overview:
- Shares the single DRAM controller port between two 68k-style bus masters: port 0 is the cache controller (line fills and write-through) and port 1 is a DMA/video requester.
- Grants one master at a time and holds the grant for the whole bus cycle, including 8-word burst fills.
- Forwards the granted master's strobes, address and write data to the DRAM controller, and routes DRAM Dtack back to that master only.
- Enforces a bounded-starvation priority scheme, with a mandatory idle gap between grants.

Parameters:
- MAX_CONSEC, 4: maximum consecutive port-0 grants while port 1 is waiting; port 1 is then served next.
- GAP_CYCLES, 1: number of Release cycles with all DRAM strobes inactive between grants (range 1..15).

Ports:
- Clock  in  1  system clock; all state changes on the rising edge
- Reset_L  in  1  asynchronous, active-low reset
- Select0_L, AS0_L, WE0_L, UDS0_L, LDS0_L  in  1 each  port 0 select/bus strobes, active low
- Addr0  in  32  port 0 address
- Data0  in  16  port 0 write data
- Dtack0_L  out  1  Dtack to port 0
- Select1_L, AS1_L, WE1_L, UDS1_L, LDS1_L  in  1 each  port 1 select/bus strobes, active low
- Addr1  in  32  port 1 address
- Data1  in  16  port 1 write data
- Dtack1_L  out  1  Dtack to port 1
- DramSelect_L, DramAS_L, DramWE_L, DramUDS_L, DramLDS_L  out  1 each  strobes to DRAM controller
- DramAddr  out  32  address to DRAM controller
- DramData  out  16  write data to DRAM controller
- DramDtack_L  in  1  Dtack from DRAM controller
- Grant  out  2  one-hot: bit0 = port 0 owns DRAM, bit1 = port 1 owns DRAM
- ArbState  out  2  current state, for debug

Behaviour:
- Read data from the DRAM controller goes to both masters directly and is not routed through this block.
- ReqN is true when SelectN_L==0 and ASN_L==0.
- States and encodings: Idle=0, Grant0=1, Grant1=2, Release=3.
- Reset (asynchronous, any state, including mid-burst):
  - state Idle; starvation counter StarveCnt=0; gap counter=0.
  - Grant=00; Dtack0_L=Dtack1_L=1.
  - All Dram* strobes=1, DramAddr=0, DramData=0.
- Outputs are combinational from the current state plus the selected port:
  - Idle/Release: all Dram* strobes=1, DramAddr=0, DramData=0, both Dtack=1, Grant=00.
  - GrantN: Dram* strobes/Addr/Data = port N's inputs; DtackN_L=DramDtack_L; other port's Dtack=1; Grant bit N=1.
- Idle decision, evaluated every cycle:
  - Req0 and (!Req1 or StarveCnt<MAX_CONSEC) -> Grant0. If Req1 is also true, StarveCnt increments (saturating at MAX_CONSEC).
  - Otherwise, if Req1 -> Grant1, and StarveCnt=0.
  - Otherwise stay in Idle.
- Grant latency: a request seen in Idle is driven to DRAM on the next cycle. Minimum one cycle from request to DramAS_L low.
- A request withdrawn before the Idle sampling edge gets no grant and leaves StarveCnt unchanged.
- In GrantN: stay while ReqN is true. When ASN_L==1 or SelectN_L==1 -> Release, and load gap counter with GAP_CYCLES-1.
  - The other port's requests are ignored while a grant is held; there is no preemption.
- Release: strobes inactive. When gap counter==0 -> Idle, else decrement. This guarantees the DRAM controller sees AS high for at least GAP_CYCLES cycles.
- No grant goes directly from one port to the other; Release always intervenes.
- If DramDtack_L arrives while not in a Grant state, it is ignored (both Dtack stay 1).
- StarveCnt is 3 bits wide (sized for MAX_CONSEC ≤ 7) and never wraps.

Test Plan:
- Reset mid-Grant0 burst:
  - Stimulus: Req0 held, assert Reset_L=0 for 1 cycle.
  - Response: immediately Grant=00, DramAS_L=1, Dtack0_L=1. Arbiter returns to Idle and re-grants port 0 one cycle after Reset_L rises.
- Single port-0 read:
  - Stimulus: Req0 at cycle 0 with Addr0=0x00080010, DramDtack_L low at cycle 5.
  - Response: Grant=01 and DramAddr=0x00080010 from cycle 1; Dtack0_L low at cycle 5; after AS0_L rises, one Release cycle, then Idle.
- Contention:
  - Stimulus: Req0 and Req1 asserted together, each master re-requesting immediately after its cycle ends.
  - Response: grant order 0,0,0,0,1,0,... with MAX_CONSEC=4.
- Port 1 only:
  - Stimulus: WE1_L=0, Data1=0xBEEF, Addr1=0x00100000.
  - Response: DramData=0xBEEF, DramWE_L=0 during Grant1; Dtack0_L stays 1 throughout.
- Burst hold:
  - Stimulus: Req0 held for 12 cycles while Req1 arrives at cycle 3.
  - Response: Grant stays 01 for all 12 cycles. Then Release for GAP_CYCLES (test GAP_CYCLES=1 and 3). Grant=10 follows, with no overlapping strobes.
- Early withdrawal:
  - Stimulus: Req1 pulses for a single cycle in Release.
  - Response: no grant to port 1; StarveCnt unchanged.

Source files
------------

// File: rtl/dram_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// dram_port_arbiter_if
//
// Groups every bus signal around the DRAM port arbiter into a single bundle:
// the two 68k-style master ports, the DRAM controller side and the debug
// outputs. Signal names follow the existing board-level naming.
//
// Modports:
//   master : the environment around the arbiter. It drives the two masters'
//            select/strobes/address/write data and the DRAM controller's
//            Dtack, and observes the per-port Dtacks, the forwarded DRAM
//            strobes/address/data, Grant and ArbState.
//   slave  : the arbiter itself, the mirror image of master.
//
// Signals (all strobes active low):
//   Select0_L, AS0_L, WE0_L, UDS0_L, LDS0_L, Addr0[31:0], Data0[15:0], Dtack0_L
//       port 0 (cache controller: line fills and write-through)
//   Select1_L, AS1_L, WE1_L, UDS1_L, LDS1_L, Addr1[31:0], Data1[15:0], Dtack1_L
//       port 1 (DMA / video requester)
//   DramSelect_L, DramAS_L, DramWE_L, DramUDS_L, DramLDS_L, DramAddr[31:0],
//   DramData[15:0], DramDtack_L
//       single DRAM controller port
//   Grant[1:0]    one-hot owner of the DRAM port (bit0 = port 0, bit1 = port 1)
//   ArbState[1:0] arbiter state for debug
// -----------------------------------------------------------------------------
interface dram_port_arbiter_if;

    // Port 0: cache controller
    logic        Select0_L;
    logic        AS0_L;
    logic        WE0_L;
    logic        UDS0_L;
    logic        LDS0_L;
    logic [31:0] Addr0;
    logic [15:0] Data0;
    logic        Dtack0_L;

    // Port 1: DMA / video requester
    logic        Select1_L;
    logic        AS1_L;
    logic        WE1_L;
    logic        UDS1_L;
    logic        LDS1_L;
    logic [31:0] Addr1;
    logic [15:0] Data1;
    logic        Dtack1_L;

    // DRAM controller side
    logic        DramSelect_L;
    logic        DramAS_L;
    logic        DramWE_L;
    logic        DramUDS_L;
    logic        DramLDS_L;
    logic [31:0] DramAddr;
    logic [15:0] DramData;
    logic        DramDtack_L;

    // Ownership and debug
    logic [1:0]  Grant;
    logic [1:0]  ArbState;

    modport master (
        output Select0_L, AS0_L, WE0_L, UDS0_L, LDS0_L, Addr0, Data0,
        output Select1_L, AS1_L, WE1_L, UDS1_L, LDS1_L, Addr1, Data1,
        output DramDtack_L,
        input  Dtack0_L, Dtack1_L,
        input  DramSelect_L, DramAS_L, DramWE_L, DramUDS_L, DramLDS_L,
        input  DramAddr, DramData,
        input  Grant, ArbState
    );

    modport slave (
        input  Select0_L, AS0_L, WE0_L, UDS0_L, LDS0_L, Addr0, Data0,
        input  Select1_L, AS1_L, WE1_L, UDS1_L, LDS1_L, Addr1, Data1,
        input  DramDtack_L,
        output Dtack0_L, Dtack1_L,
        output DramSelect_L, DramAS_L, DramWE_L, DramUDS_L, DramLDS_L,
        output DramAddr, DramData,
        output Grant, ArbState
    );

endinterface

// File: rtl/dram_port_arbiter.sv
// -----------------------------------------------------------------------------
// dram_port_arbiter
//
// Shares the single DRAM controller port between two 68k-style bus masters.
// Port 0 is the cache controller, port 1 a DMA/video requester. One master
// owns the port at a time and keeps it for its whole bus cycle (including
// 8-word burst fills, which simply hold AS low). While it owns the port its
// strobes, address and write data are forwarded to the DRAM controller and
// the controller's Dtack is routed back to it alone. Read data from DRAM goes
// to both masters directly and does not pass through this block.
//
// Priority: port 0 wins in Idle, but while port 1 is also waiting it may win
// at most MAX_CONSEC times in a row; port 1 is then served next. Every grant
// is followed by GAP_CYCLES Release cycles with all DRAM strobes inactive, so
// ownership never passes directly from one port to the other.
//
// Parameters:
//   MAX_CONSEC  consecutive port-0 grants allowed while port 1 waits (<= 7)
//   GAP_CYCLES  Release cycles between grants (1..15)
//
// Ports:
//   Clock    system clock, rising edge
//   Reset_L  asynchronous, active-low reset
//   bus      dram_port_arbiter_if.slave: master ports, DRAM port, Grant,
//            ArbState
// -----------------------------------------------------------------------------
module dram_port_arbiter #(
    parameter int MAX_CONSEC = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                 Clock,
    input  logic                 Reset_L,
    dram_port_arbiter_if.slave   bus
);

    // Encodings are visible on ArbState, so they are fixed explicitly.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT0  = 2'd1,
        GRANT1  = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    // The starvation counter is 3 bits wide and the gap counter 4 bits wide.
    localparam logic [2:0] MAX_CNT  = 3'(MAX_CONSEC);
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    arb_state_t  state;
    logic [2:0]  starve_cnt;   // port-0 wins since port 1 last got the port
    logic [3:0]  gap_cnt;      // remaining Release cycles minus one

    logic        req0;
    logic        req1;

    // A master requests the DRAM when it is selected and has AS asserted.
    assign req0 = !bus.Select0_L && !bus.AS0_L;
    assign req1 = !bus.Select1_L && !bus.AS1_L;

    // -------------------------------------------------------------------------
    // Arbitration state machine
    // -------------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            state      <= IDLE;
            starve_cnt <= '0;
            gap_cnt    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register here updates from values sampled before the edge.
            case (state)
                IDLE: begin
                    if (req0 && (!req1 || starve_cnt < MAX_CNT)) begin
                        state <= GRANT0;
                        // Only a port-0 win over a waiting port 1 counts
                        // towards starvation; the count saturates.
                        if (req1 && starve_cnt != MAX_CNT) begin
                            starve_cnt <= starve_cnt + 3'd1;
                        end
                    end else if (req1) begin
                        state      <= GRANT1;
                        starve_cnt <= '0;
                    end
                end

                // The grant is held for as long as the owner keeps its
                // request up; the other port is not considered (no
                // preemption), which keeps bursts intact.
                GRANT0: begin
                    if (!req0) begin
                        state   <= RELEASE;
                        gap_cnt <= GAP_LOAD;
                    end
                end

                GRANT1: begin
                    if (!req1) begin
                        state   <= RELEASE;
                        gap_cnt <= GAP_LOAD;
                    end
                end

                // Requests are not looked at here: anything that rises and
                // falls again before Idle samples it gets no grant and does
                // not touch the starvation counter.
                RELEASE: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output steering
    //
    // The owner is decoded from the registered state only; the forwarded
    // strobes follow the owner's inputs combinationally so a burst sees no
    // extra pipeline delay. Outside a grant the DRAM side is parked inactive
    // and any stray DRAM Dtack is dropped.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // case statement can leave a latch behind.
        bus.DramSelect_L = 1'b1;
        bus.DramAS_L     = 1'b1;
        bus.DramWE_L     = 1'b1;
        bus.DramUDS_L    = 1'b1;
        bus.DramLDS_L    = 1'b1;
        bus.DramAddr     = '0;
        bus.DramData     = '0;
        bus.Dtack0_L     = 1'b1;
        bus.Dtack1_L     = 1'b1;
        bus.Grant        = 2'b00;

        case (state)
            GRANT0: begin
                bus.DramSelect_L = bus.Select0_L;
                bus.DramAS_L     = bus.AS0_L;
                bus.DramWE_L     = bus.WE0_L;
                bus.DramUDS_L    = bus.UDS0_L;
                bus.DramLDS_L    = bus.LDS0_L;
                bus.DramAddr     = bus.Addr0;
                bus.DramData     = bus.Data0;
                bus.Dtack0_L     = bus.DramDtack_L;
                bus.Grant        = 2'b01;
            end

            GRANT1: begin
                bus.DramSelect_L = bus.Select1_L;
                bus.DramAS_L     = bus.AS1_L;
                bus.DramWE_L     = bus.WE1_L;
                bus.DramUDS_L    = bus.UDS1_L;
                bus.DramLDS_L    = bus.LDS1_L;
                bus.DramAddr     = bus.Addr1;
                bus.DramData     = bus.Data1;
                bus.Dtack1_L     = bus.DramDtack_L;
                bus.Grant        = 2'b10;
            end

            default: begin
                // Idle and Release keep the parked defaults.
            end
        endcase
    end

    assign bus.ArbState = state;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dram_port_arbiter
//
// Self-checking bench for dram_port_arbiter. Two instances share one set of
// stimulus: dut (MAX_CONSEC=4, GAP_CYCLES=1) is the main target, dut3
// (GAP_CYCLES=3) is compared against it where the Release length matters.
// Inputs change 1 time unit after the rising edge; outputs are sampled one
// further time unit later.
// -----------------------------------------------------------------------------
module tb_dram_port_arbiter;

    localparam logic [31:0] A0 = 32'h0008_0010;
    localparam logic [15:0] D0 = 16'h1234;
    localparam logic [31:0] A1 = 32'h0010_0000;
    localparam logic [15:0] D1 = 16'hBEEF;

    logic Clock = 1'b0;
    logic Reset_L;

    always #5 Clock = ~Clock;

    dram_port_arbiter_if bus ();
    dram_port_arbiter_if bus3 ();

    dram_port_arbiter #(.MAX_CONSEC(4), .GAP_CYCLES(1)) dut (
        .Clock   (Clock),
        .Reset_L (Reset_L),
        .bus     (bus)
    );

    dram_port_arbiter #(.MAX_CONSEC(4), .GAP_CYCLES(3)) dut3 (
        .Clock   (Clock),
        .Reset_L (Reset_L),
        .bus     (bus3)
    );

    // dut3 sees exactly the stimulus given to dut.
    assign bus3.Select0_L   = bus.Select0_L;
    assign bus3.AS0_L       = bus.AS0_L;
    assign bus3.WE0_L       = bus.WE0_L;
    assign bus3.UDS0_L      = bus.UDS0_L;
    assign bus3.LDS0_L      = bus.LDS0_L;
    assign bus3.Addr0       = bus.Addr0;
    assign bus3.Data0       = bus.Data0;
    assign bus3.Select1_L   = bus.Select1_L;
    assign bus3.AS1_L       = bus.AS1_L;
    assign bus3.WE1_L       = bus.WE1_L;
    assign bus3.UDS1_L      = bus.UDS1_L;
    assign bus3.LDS1_L      = bus.LDS1_L;
    assign bus3.Addr1       = bus.Addr1;
    assign bus3.Data1       = bus.Data1;
    assign bus3.DramDtack_L = bus.DramDtack_L;

    int n_checks = 0;
    int n_errors = 0;

    // One cycle of stimulus plus the outputs expected during that cycle.
    typedef struct {
        logic        r0;    // port 0 requests (Select0_L = AS0_L = 0)
        logic        we0;   // WE0_L
        logic        r1;    // port 1 requests
        logic        we1;   // WE1_L
        logic        dt;    // DramDtack_L
        logic [1:0]  st;    // ArbState
        logic [1:0]  gnt;   // Grant
        logic [1:0]  dtk;   // {Dtack1_L, Dtack0_L}
        logic [4:0]  stb;   // {DramSelect_L, DramAS_L, DramWE_L, DramUDS_L, DramLDS_L}
        logic [31:0] addr;  // DramAddr
        logic [15:0] data;  // DramData
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic r0, input logic we0, input logic r1,
                         input logic we1, input logic dt);
        bus.Select0_L   = !r0;
        bus.AS0_L       = !r0;
        bus.WE0_L       = we0;
        bus.Select1_L   = !r1;
        bus.AS1_L       = !r1;
        bus.WE1_L       = we1;
        bus.DramDtack_L = dt;
    endtask

    task automatic add(input logic r0, input logic we0, input logic r1, input logic we1,
                       input logic dt, input logic [1:0] st, input logic [1:0] gnt,
                       input logic [1:0] dtk, input logic [4:0] stb,
                       input logic [31:0] addr, input logic [15:0] data);
        vec_t v;
        v.r0 = r0; v.we0 = we0; v.r1 = r1; v.we1 = we1; v.dt = dt;
        v.st = st; v.gnt = gnt; v.dtk = dtk; v.stb = stb; v.addr = addr; v.data = data;
        vecs.push_back(v);
    endtask

    // Leaves both instances in Idle at 1 time unit after a rising edge.
    task automatic do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        Reset_L = 1'b0;
        @(posedge Clock);
        @(posedge Clock);
        #1;
        Reset_L = 1'b1;
    endtask

    // Both masters request continuously; each owner holds for two cycles,
    // drops its request for one cycle and re-requests during Release.
    // Bit k of exp1 set means grant k must go to port 1.
    task automatic contend(input string tag, input int n, input logic [7:0] exp1);
        logic [1:0] g;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < n; k++) begin
            g = 2'b00;
            for (int w = 0; w < 8 && g == 2'b00; w++) begin
                #1;
                g = bus.Grant;
                if (g == 2'b00) next();
            end
            check($sformatf("%s.grant%0d", tag, k), 32'(g), exp1[k] ? 32'h2 : 32'h1);
            next();
            drive(g != 2'b01, 1'b1, g != 2'b10, 1'b1, 1'b1);
            next();
            if (k < n - 1) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            else           drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        end
    endtask

    function automatic logic [1:0] burst_state(input int gap, input int c);
        // Cycles 13.. after the burst: gap Release cycles, one Idle, then Grant1.
        int rel;
        rel = c - 13;
        if (rel < gap)       return 2'd3;
        else if (rel == gap) return 2'd0;
        else                 return 2'd2;
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.Addr0  = A0;
        bus.Data0  = D0;
        bus.UDS0_L = 1'b0;
        bus.LDS0_L = 1'b1;
        bus.Addr1  = A1;
        bus.Data1  = D1;
        bus.UDS1_L = 1'b1;
        bus.LDS1_L = 1'b0;

        // ---- Reset state, with both masters requesting and Dtack low ----
        Reset_L = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #3;
        check("reset.state", 32'(bus.ArbState), 32'h0);
        check("reset.grant", 32'(bus.Grant), 32'h0);
        check("reset.dtack", 32'({bus.Dtack1_L, bus.Dtack0_L}), 32'h3);
        check("reset.strobes", 32'({bus.DramSelect_L, bus.DramAS_L, bus.DramWE_L,
                                    bus.DramUDS_L, bus.DramLDS_L}), 32'h1f);
        check("reset.addr", bus.DramAddr, 32'h0);
        check("reset.data", 32'(bus.DramData), 32'h0);
        do_reset();

        // ---- Table: port-0 read, then port-1 write ----
        //   r0  we0  r1  we1  dt    st     gnt    dtk    stb       addr data
        add(1, 1, 0, 1, 1, 2'd0, 2'b00, 2'b11, 5'b11111, 32'h0, 16'h0);  // c0 request seen
        add(1, 1, 0, 1, 1, 2'd1, 2'b01, 2'b11, 5'b00101, A0, D0);        // c1 granted
        add(1, 1, 0, 1, 1, 2'd1, 2'b01, 2'b11, 5'b00101, A0, D0);
        add(1, 1, 0, 1, 1, 2'd1, 2'b01, 2'b11, 5'b00101, A0, D0);
        add(1, 1, 0, 1, 1, 2'd1, 2'b01, 2'b11, 5'b00101, A0, D0);
        add(1, 1, 0, 1, 0, 2'd1, 2'b01, 2'b10, 5'b00101, A0, D0);        // c5 Dtack0 low
        add(0, 1, 0, 1, 1, 2'd1, 2'b01, 2'b11, 5'b11101, A0, D0);        // c6 AS0 rises
        add(0, 1, 0, 1, 1, 2'd3, 2'b00, 2'b11, 5'b11111, 32'h0, 16'h0);  // c7 Release
        add(0, 1, 0, 1, 0, 2'd0, 2'b00, 2'b11, 5'b11111, 32'h0, 16'h0);  // c8 stray Dtack in Idle
        add(0, 1, 1, 0, 1, 2'd0, 2'b00, 2'b11, 5'b11111, 32'h0, 16'h0);  // c9 port-1 write
        add(0, 1, 1, 0, 1, 2'd2, 2'b10, 2'b11, 5'b00010, A1, D1);
        add(0, 1, 1, 0, 1, 2'd2, 2'b10, 2'b11, 5'b00010, A1, D1);
        add(0, 1, 1, 0, 0, 2'd2, 2'b10, 2'b01, 5'b00010, A1, D1);        // Dtack1 only
        add(0, 1, 0, 0, 1, 2'd2, 2'b10, 2'b11, 5'b11010, A1, D1);        // AS1 rises
        add(0, 1, 0, 0, 0, 2'd3, 2'b00, 2'b11, 5'b11111, 32'h0, 16'h0);  // stray Dtack in Release
        add(0, 1, 0, 1, 1, 2'd0, 2'b00, 2'b11, 5'b11111, 32'h0, 16'h0);
        add(1, 0, 0, 1, 1, 2'd0, 2'b00, 2'b11, 5'b11111, 32'h0, 16'h0);  // port-0 write
        add(1, 0, 0, 1, 1, 2'd1, 2'b01, 2'b11, 5'b00001, A0, D0);
        add(0, 1, 0, 1, 1, 2'd1, 2'b01, 2'b11, 5'b11101, A0, D0);
        add(0, 1, 0, 1, 1, 2'd3, 2'b00, 2'b11, 5'b11111, 32'h0, 16'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].r0, vecs[i].we0, vecs[i].r1, vecs[i].we1, vecs[i].dt);
            #1;
            check($sformatf("vec%0d.state", i), 32'(bus.ArbState), 32'(vecs[i].st));
            check($sformatf("vec%0d.grant", i), 32'(bus.Grant), 32'(vecs[i].gnt));
            check($sformatf("vec%0d.dtack", i), 32'({bus.Dtack1_L, bus.Dtack0_L}),
                  32'(vecs[i].dtk));
            check($sformatf("vec%0d.strobes", i), 32'({bus.DramSelect_L, bus.DramAS_L,
                  bus.DramWE_L, bus.DramUDS_L, bus.DramLDS_L}), 32'(vecs[i].stb));
            check($sformatf("vec%0d.addr", i), bus.DramAddr, vecs[i].addr);
            check($sformatf("vec%0d.data", i), 32'(bus.DramData), 32'(vecs[i].data));
            next();
        end

        // ---- Contention: order 0,0,0,0,1,0 ----
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        next();
        contend("contend", 6, 8'b0001_0000);
        next();
        next();

        // ---- Early withdrawal: a Req1 pulse in Release is ignored ----
        do_reset();
        contend("pre", 3, 8'b0000_0000);      // StarveCnt now 3
        next();
        #1;
        check("wd.idle_grant", 32'(bus.Grant), 32'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);  // lone port-0 cycle: no increment
        next();
        #1;
        check("wd.solo_grant", 32'(bus.Grant), 32'h1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        next();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);  // Req1 pulse during Release
        #1;
        check("wd.rel_state", 32'(bus.ArbState), 32'h3);
        check("wd.rel_grant", 32'(bus.Grant), 32'h0);
        next();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        check("wd.idle1_state", 32'(bus.ArbState), 32'h0);
        next();
        #1;
        check("wd.idle2_state", 32'(bus.ArbState), 32'h0);
        check("wd.idle2_grant", 32'(bus.Grant), 32'h0);
        contend("post", 2, 8'b0000_0010);     // one more port-0 win, then port 1
        next();
        next();

        // ---- Burst hold, GAP_CYCLES = 1 (dut) and 3 (dut3) ----
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);  // cycle 0
        for (int c = 1; c <= 12; c++) begin
            next();
            if (c == 3)  drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            if (c == 12) drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
            #1;
            check($sformatf("burst.c%0d.grant", c), 32'(bus.Grant), 32'h1);
            check($sformatf("burst.c%0d.grant_g3", c), 32'(bus3.Grant), 32'h1);
        end
        for (int c = 13; c <= 19; c++) begin
            next();
            #1;
            check($sformatf("burst.c%0d.state", c), 32'(bus.ArbState), 32'(burst_state(1, c)));
            check($sformatf("burst.c%0d.state_g3", c), 32'(bus3.ArbState),
                  32'(burst_state(3, c)));
            check($sformatf("burst.c%0d.as", c), 32'(bus.DramAS_L),
                  (burst_state(1, c) == 2'd2) ? 32'h0 : 32'h1);
            check($sformatf("burst.c%0d.as_g3", c), 32'(bus3.DramAS_L),
                  (burst_state(3, c) == 2'd2) ? 32'h0 : 32'h1);
            check($sformatf("burst.c%0d.dtack0_g3", c), 32'(bus3.Dtack0_L), 32'h1);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (6) next();

        // ---- Reset in the middle of a port-0 burst ----
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        next();
        next();
        #1;
        check("rstburst.pre_grant", 32'(bus.Grant), 32'h1);
        check("rstburst.pre_dtack0", 32'(bus.Dtack0_L), 32'h0);
        Reset_L = 1'b0;
        #1;
        check("rstburst.grant", 32'(bus.Grant), 32'h0);
        check("rstburst.as", 32'(bus.DramAS_L), 32'h1);
        check("rstburst.dtack0", 32'(bus.Dtack0_L), 32'h1);
        check("rstburst.addr", bus.DramAddr, 32'h0);
        next();
        Reset_L = 1'b1;
        #1;
        check("rstburst.idle_state", 32'(bus.ArbState), 32'h0);
        next();
        #1;
        check("rstburst.regrant_state", 32'(bus.ArbState), 32'h1);
        check("rstburst.regrant", 32'(bus.Grant), 32'h1);
        check("rstburst.regrant_as", 32'(bus.DramAS_L), 32'h0);

        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (4) next();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
